// File: rtl/note_scheduler.sv
// note_scheduler: game FSM, note-to-spawn allocation, per-lane slot occupancy, score and miss tracking.
// Optional build macro SCHED_NO_REPEAT_EN: lane search skips the last accepted lane as its first choice.
// The LFSR input is named rand_val because "rand" is a reserved word in SystemVerilog.
module note_scheduler #(
  parameter int unsigned SLOTS      = 32,
  parameter int unsigned SLOT_W     = 5,
  parameter int unsigned MISS_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              note_tick,
  input  logic [4:0]        rand_val,
  input  logic              start,
  input  logic              pause,
  output logic              spawn_valid,
  output logic [1:0]        spawn_lane,
  output logic [SLOT_W-1:0] spawn_slot,
  input  logic              spawn_ready,
  input  logic              retire_valid,
  input  logic [1:0]        retire_lane,
  input  logic [SLOT_W-1:0] retire_slot,
  input  logic              retire_hit,
  output logic [1:0]        state,
  output logic [10:0]       score,
  output logic [3:0]        misses
);

  localparam int unsigned LANES     = 4;
  localparam int unsigned SCORE_W   = 11;
  localparam int unsigned MISS_W    = 4;
  localparam int unsigned SCORE_MAX = 2047;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [LANES-1:0][SLOTS-1:0]     occ_q, occ_d;
  logic                            pending_q;
  logic [LANES-1:0]                lane_has_free;
  logic [SLOT_W-1:0]               free_slot [LANES];
  logic [1:0]                      first_lane;
  logic [1:0]                      cand_lane;
  logic                            alloc_found;
  logic [1:0]                      alloc_lane;
  logic [SLOT_W-1:0]               alloc_slot;
  logic                            start_game;
  logic                            alloc_go;
  logic                            alloc_drop;
  logic                            accept;
  logic                            retire_do;
  logic                            note_capture;
  logic                            unused_rand;

  assign unused_rand  = ^rand_val[4:2];
  assign state        = state_q;
  assign start_game   = (state_q == ST_IDLE) && start;
  assign accept       = spawn_valid && spawn_ready;
  assign alloc_go     = (state_q == ST_PLAY) && frame_tick && pending_q && !spawn_valid;
  assign alloc_drop   = alloc_go && !alloc_found;
  assign note_capture = (state_q == ST_PLAY) && note_tick && !pending_q;
  assign retire_do    = retire_valid && (state_q != ST_IDLE) && occ_q[retire_lane][retire_slot];

  // Game state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Game state transitions; miss limit takes priority over a pause request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (misses == MISS_W'(MISS_LIMIT)) state_d = ST_OVER;
        else if (pause)                    state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause) state_d = ST_PLAY;
      ST_OVER:  if (start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-lane full flag and lowest-index free slot
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_has_free[l] = ~&occ_q[l];
      free_slot[l]     = '0;
      for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
        if (!occ_q[l][s]) free_slot[l] = SLOT_W'(s);
      end
    end
  end

`ifdef SCHED_NO_REPEAT_EN
  logic [1:0] last_lane_q;

  // Last accepted lane, forgotten at game start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_lane_q <= 2'd0;
    else if (start_game) last_lane_q <= 2'd0;
    else if (accept)     last_lane_q <= spawn_lane;
  end

  // First lane to search, stepping past a repeat of the last accepted lane
  always_comb begin
    first_lane = rand_val[1:0];
    if (rand_val[1:0] == last_lane_q) first_lane = rand_val[1:0] + 2'd1;
  end
`else
  // First lane to search comes straight from the LFSR
  always_comb begin
    first_lane = rand_val[1:0];
  end
`endif

  // Lane search; scanned last-to-first so the earliest lane with room wins
  always_comb begin
    alloc_found = 1'b0;
    alloc_lane  = 2'd0;
    alloc_slot  = '0;
    cand_lane   = 2'd0;
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      cand_lane = first_lane + 2'(k);
      if (lane_has_free[cand_lane]) begin
        alloc_found = 1'b1;
        alloc_lane  = cand_lane;
        alloc_slot  = free_slot[cand_lane];
      end
    end
  end

  // Next occupancy: retire clears, accepted spawn sets, game start wipes
  always_comb begin
    occ_d = occ_q;
    if (retire_do) occ_d[retire_lane][retire_slot] = 1'b0;
    if (accept)    occ_d[spawn_lane][spawn_slot]   = 1'b1;
    if (start_game) occ_d = '0;
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  // One queued note; later ticks are dropped until it is spawned or discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pending_q <= 1'b0;
    else if (start_game)           pending_q <= 1'b0;
    else if (note_capture)         pending_q <= 1'b1;
    else if (accept || alloc_drop) pending_q <= 1'b0;
  end

  // Spawn request held stable until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_valid <= 1'b0;
      spawn_lane  <= 2'd0;
      spawn_slot  <= '0;
    end else if (accept) begin
      spawn_valid <= 1'b0;
    end else if (alloc_go && alloc_found) begin
      spawn_valid <= 1'b1;
      spawn_lane  <= alloc_lane;
      spawn_slot  <= alloc_slot;
    end
  end

  // Saturating hit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          score <= '0;
    else if (start_game) score <= '0;
    else if (retire_do && retire_hit && (score != SCORE_W'(SCORE_MAX)))
      score <= score + SCORE_W'(1);
  end

  // Miss counter saturating at the game-over limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          misses <= '0;
    else if (start_game) misses <= '0;
    else if (retire_do && !retire_hit && (misses != MISS_W'(MISS_LIMIT)))
      misses <= misses + MISS_W'(1);
  end

endmodule
